fetch_unit: RTL

Instruction-fetch stage that consumes the next-PC value produced downstream and turns it into instruction-memory requests. It owns the architectural PC register, fetches one instruction at a time over a req/ack memory interface, and presents the instruction and its PC to decode with a valid/ready handshake. It is single-issue and non-speculative: fetch N+1 starts only after decode/execute has returned the next PC for instruction N.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Single-issue, non-speculative instruction fetch stage: owns the PC, fetches one
// word at a time over req/ack and hands it to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_in,
    input  logic        npc_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        misalign_fault,
    output logic [31:0] fetch_count,
    output logic [1:0]  dbg_state
);

    // Handshakes: imem transfer when imem_req && imem_ack at a rising edge;
    // decode transfer when inst_valid && inst_ready at a rising edge.
    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_DELIVER  = 2'd1,
        S_WAIT_NPC = 2'd2,
        S_HALT     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        misalign_fault_q, misalign_fault_d;
    logic        imem_req_q, imem_req_d;
    logic        inst_valid_q, inst_valid_d;
    logic        take_npc;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inst_out_d       = inst_out_q;
        pc_out_d         = pc_out_q;
        fetch_count_d    = fetch_count_q;
        misalign_fault_d = misalign_fault_q;
        take_npc         = 1'b0;

        case (state_q)
            S_FETCH: begin
                // An ack is only meaningful once the request is actually on the bus.
                if (imem_ack && imem_req_q) begin
                    inst_out_d = imem_rdata;
                    pc_out_d   = pc_q;
                    state_d    = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (inst_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = S_WAIT_NPC;
                    take_npc      = npc_valid;
                end
            end
            S_WAIT_NPC: begin
                take_npc = npc_valid;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (take_npc) begin
            if (npc_in[1:0] == 2'b00) begin
                pc_d    = npc_in;
                state_d = S_FETCH;
            end else begin
                misalign_fault_d = 1'b1;
                state_d          = S_HALT;
            end
        end

        // Registered strobes follow the state being entered.
        imem_req_d   = (state_d == S_FETCH);
        inst_valid_d = (state_d == S_DELIVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_FETCH;
            pc_q             <= RESET_PC;
            inst_out_q       <= 32'd0;
            pc_out_q         <= 32'd0;
            fetch_count_q    <= 32'd0;
            misalign_fault_q <= 1'b0;
            imem_req_q       <= 1'b0;
            inst_valid_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inst_out_q       <= inst_out_d;
            pc_out_q         <= pc_out_d;
            fetch_count_q    <= fetch_count_d;
            misalign_fault_q <= misalign_fault_d;
            imem_req_q       <= imem_req_d;
            inst_valid_q     <= inst_valid_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst_out       = inst_out_q;
    assign pc_out         = pc_out_q;
    assign misalign_fault = misalign_fault_q;
    assign fetch_count    = fetch_count_q;
    assign dbg_state      = state_q;

endmodule
